l2_snoop_responder: RTL and testbench

- Sits directly south of one L1 data cache and consumes that cache's snooper-side traffic: line-fill reads, and dirty-line evictions with their 128-bit cacheline.
- Models the L2/memory as a line-granular backing store with a fixed, parameterised access latency.
- Returns fill data as a pulse that the L1 accepts as a line update.
- Buffers one eviction at a time and drains it into the store in a free cycle.

---
 rtl/l2_snoop_responder.sv | 210 +++++++++++++++++++++
 tb/tb_l2_snoop_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_snoop_responder.sv
// Line-granular L2 model behind one L1: fixed-latency line fills plus a one-entry eviction buffer.
// Optional build macro L2_EVICT_FWD_EN forwards a matching buffered eviction at the read slot.
module l2_snoop_responder #(
    parameter int LATENCY = 8,
    parameter int LINE_AW = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  req_addr,
    input  logic         req_read_valid,
    input  logic         req_evict_wren,
    input  logic [127:0] evict_cacheline,
    input  logic         hotlink_interrupt,
    output logic [127:0] resp_cacheline,
    output logic         resp_valid,
    output logic         busy,
    output logic         wb_pending,
    output logic         protocol_error
);

    localparam int          LINES    = 1 << LINE_AW;
    localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [LINE_AW-1:0] line_index(input logic [31:0] addr);
        return addr[LINE_AW+3:4];
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [7:0]           cnt_r;
    logic [7:0]           cnt_s;
    logic [LINE_AW-1:0]   rd_idx_r;
    logic [LINE_AW-1:0]   rd_idx_s;
    logic [LINE_AW-1:0]   req_idx_s;

    logic                 wb_valid_r;
    logic                 wb_valid_s;
    logic [LINE_AW-1:0]   wb_addr_r;
    logic [LINE_AW-1:0]   wb_addr_s;
    logic [127:0]         wb_data_r;
    logic [127:0]         wb_data_s;

    logic [127:0]         resp_cacheline_r;
    logic [127:0]         resp_line_s;
    logic                 resp_valid_r;
    logic                 resp_valid_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 protocol_error_r;
    logic                 protocol_error_s;

    logic                 slot_due_s;
    logic                 read_slot_s;
    logic                 fwd_hit_s;
    logic                 drain_s;
    logic                 ev_accept_s;
    logic                 ev_drop_s;
    logic                 rd_drop_s;

    logic [127:0]         mem_r [0:LINES-1];

    logic                 unused_addr_bits_s;
    assign unused_addr_bits_s = ^{req_addr[31:LINE_AW+4], req_addr[3:0]};

    assign req_idx_s = line_index(req_addr);

    // Read-slot arbitration between the pending fill and the buffered eviction.
    always_comb begin
        slot_due_s = (state_r == ST_WAIT) && (cnt_r == 8'd0);
`ifdef L2_EVICT_FWD_EN
        read_slot_s = slot_due_s;
        fwd_hit_s   = slot_due_s && wb_valid_r && (wb_addr_r == rd_idx_r);
`else
        // Without forwarding the drain wins and the read slips one cycle.
        read_slot_s = slot_due_s && !wb_valid_r;
        fwd_hit_s   = 1'b0;
`endif
        drain_s     = wb_valid_r && !read_slot_s;
        ev_accept_s = req_evict_wren && (!wb_valid_r || drain_s);
        ev_drop_s   = req_evict_wren && wb_valid_r && !drain_s;
        rd_drop_s   = req_read_valid && (state_r != ST_IDLE);
    end

    // Read FSM next-state and counter.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rd_idx_s = rd_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (req_read_valid) begin
                    state_s  = ST_WAIT;
                    cnt_s    = CNT_LOAD;
                    rd_idx_s = req_idx_s;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r != 8'd0) begin
                    cnt_s = cnt_r - 8'd1;
                end else if (read_slot_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (!hotlink_interrupt) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        resp_valid_s     = (state_s == ST_RESP);
        busy_s           = (state_s != ST_IDLE);
        protocol_error_s = protocol_error_r | rd_drop_s | ev_drop_s;
        if (read_slot_s) begin
            resp_line_s = fwd_hit_s ? wb_data_r : mem_r[rd_idx_r];
        end else begin
            resp_line_s = resp_cacheline_r;
        end
    end

    // Eviction buffer next values.
    always_comb begin
        wb_valid_s = wb_valid_r;
        wb_addr_s  = wb_addr_r;
        wb_data_s  = wb_data_r;
        if (ev_accept_s) begin
            wb_valid_s = 1'b1;
            wb_addr_s  = req_idx_s;
            wb_data_s  = evict_cacheline;
        end else if (drain_s) begin
            wb_valid_s = 1'b0;
        end else begin
            wb_valid_s = wb_valid_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            rd_idx_r <= '0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rd_idx_r <= rd_idx_s;
        end
    end

    // Eviction buffer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_r <= 1'b0;
            wb_addr_r  <= '0;
            wb_data_r  <= 128'd0;
        end else begin
            wb_valid_r <= wb_valid_s;
            wb_addr_r  <= wb_addr_s;
            wb_data_r  <= wb_data_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_cacheline_r <= 128'd0;
            resp_valid_r     <= 1'b0;
            busy_r           <= 1'b0;
            protocol_error_r <= 1'b0;
        end else begin
            resp_cacheline_r <= resp_line_s;
            resp_valid_r     <= resp_valid_s;
            busy_r           <= busy_s;
            protocol_error_r <= protocol_error_s;
        end
    end

    // Backing store keeps its contents across reset; only the drain writes it.
    always_ff @(posedge clk) begin
        if (!reset && drain_s) begin
            mem_r[wb_addr_r] <= wb_data_r;
        end
    end

    assign resp_cacheline = resp_cacheline_r;
    assign resp_valid     = resp_valid_r;
    assign busy           = busy_r;
    assign wb_pending     = wb_valid_r;
    assign protocol_error = protocol_error_r;

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Self-checking bench for l2_snoop_responder: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the responder.
module tb_l2_snoop_responder;

    localparam int LAT = 8;
`ifdef L2_EVICT_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  req_addr = 32'd0;
    logic         req_read_valid = 1'b0;
    logic         req_evict_wren = 1'b0;
    logic [127:0] evict_cacheline = 128'd0;
    logic         hotlink_interrupt = 1'b0;
    logic [127:0] resp_cacheline;
    logic         resp_valid;
    logic         busy;
    logic         wb_pending;
    logic         protocol_error;

    l2_snoop_responder #(.LATENCY(LAT), .LINE_AW(10)) dut (
        .clk(clk),
        .reset(reset),
        .req_addr(req_addr),
        .req_read_valid(req_read_valid),
        .req_evict_wren(req_evict_wren),
        .evict_cacheline(evict_cacheline),
        .hotlink_interrupt(hotlink_interrupt),
        .resp_cacheline(resp_cacheline),
        .resp_valid(resp_valid),
        .busy(busy),
        .wb_pending(wb_pending),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Transaction-level model: a pending read is a target cycle, not a counter.
    logic [127:0] mmem [0:1023];
    logic         m_busy = 1'b0;
    logic         m_resp = 1'b0;
    logic [9:0]   m_idx  = 10'd0;
    int           m_slot = 0;
    logic [127:0] m_data = 128'd0;
    logic         m_err  = 1'b0;
    logic         m_wbv  = 1'b0;
    logic [9:0]   m_wba  = 10'd0;
    logic [127:0] m_wbd  = 128'd0;

    localparam logic [127:0] D1 = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    localparam logic [127:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit was_busy, in_resp, wbv, due, slot, drain;
        if (reset) begin
            m_busy = 1'b0; m_resp = 1'b0; m_data = 128'd0; m_err = 1'b0; m_wbv = 1'b0;
        end else begin
            was_busy = m_busy;
            in_resp  = m_resp;
            wbv      = m_wbv;
            due      = was_busy && !in_resp && (cyc >= m_slot);
            slot     = due && (FWD || !wbv);
            if (due && !slot) m_slot = cyc + 1;
            drain    = wbv && !slot;
            if (slot) m_data = (FWD && wbv && (m_wba == m_idx)) ? m_wbd : mmem[m_idx];
            if (in_resp && !hotlink_interrupt) begin
                m_busy = 1'b0; m_resp = 1'b0;
            end
            if (slot) m_resp = 1'b1;
            if (req_read_valid) begin
                if (was_busy) m_err = 1'b1;
                else begin
                    m_busy = 1'b1; m_idx = req_addr[13:4]; m_slot = cyc + LAT - 1;
                end
            end
            if (drain) mmem[m_wba] = m_wbd;
            if (req_evict_wren) begin
                if (!wbv || drain) begin
                    m_wbv = 1'b1; m_wba = req_addr[13:4]; m_wbd = evict_cacheline;
                end else m_err = 1'b1;
            end else if (drain) m_wbv = 1'b0;
        end
        cyc++;
    endtask

    task automatic compare();
        chk1("m_resp_valid", resp_valid, m_resp);
        chk1("m_busy", busy, m_busy);
        chk1("m_wb_pending", wb_pending, m_wbv);
        chk1("m_protocol_error", protocol_error, m_err);
        chk128("m_resp_cacheline", resp_cacheline, m_data);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic start_read(input logic [31:0] a);
        req_addr = a; req_read_valid = 1'b1;
        cycle();
        req_read_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [9:0]  idx;
        int          exp_t;
        for (int i = 0; i < 1024; i++) mmem[i] = 128'd0;

        reset = 1'b1;
        run(2);
        reset = 1'b0;
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_perr", protocol_error, 1'b0);

        // Basic read of an untouched line.
        start_read(32'h0000_1230);
        chk1("t1_busy_T1", busy, 1'b1);
        for (int k = 2; k <= 9; k++) begin
            cycle();
            chk1("t1_valid", resp_valid, (k == 8));
            chk1("t1_busy", busy, (k <= 8));
            if (k == 8) chk128("t1_data", resp_cacheline, 128'd0);
        end

        // Eviction then read-back.
        req_addr = 32'h0000_0040; evict_cacheline = D1; req_evict_wren = 1'b1;
        cycle();
        req_evict_wren = 1'b0;
        chk1("t2_wbp_on", wb_pending, 1'b1);
        cycle();
        chk1("t2_wbp_off", wb_pending, 1'b0);
        start_read(32'h0000_0040);
        run(7);
        chk1("t2_valid", resp_valid, 1'b1);
        chk128("t2_data", resp_cacheline, D1);
        run(1);

        // Eviction to the read line still buffered at the read slot.
        start_read(32'h0000_0080);
        run(5);
        req_addr = 32'h0000_0080; evict_cacheline = D2; req_evict_wren = 1'b1;
        cycle();
        req_evict_wren = 1'b0;
        exp_t = FWD ? 8 : 9;
        for (int k = 8; k <= 10; k++) begin
            cycle();
            chk1("t3_valid", resp_valid, (k == exp_t));
            if (k == exp_t) chk128("t3_data", resp_cacheline, D2);
        end

        // Hotlink stall holds the response for four cycles.
        start_read(32'h0000_0040);
        run(7);
        chk1("t4_valid_first", resp_valid, 1'b1);
        for (int k = 9; k <= 12; k++) begin
            hotlink_interrupt = (k <= 11);
            cycle();
            chk1("t4_valid", resp_valid, (k <= 11));
            if (k <= 11) chk128("t4_data", resp_cacheline, D1);
        end
        hotlink_interrupt = 1'b0;
        chk1("t4_idle", busy, 1'b0);

        // Second read while busy is dropped and flagged.
        start_read(32'h0000_0040);
        run(2);
        start_read(32'h0000_0080);
        chk1("t5_perr", protocol_error, 1'b1);
        run(4);
        chk1("t5_valid", resp_valid, 1'b1);
        chk128("t5_data", resp_cacheline, D1);
        run(5);
        chk1("t5_perr_sticky", protocol_error, 1'b1);

        // Reset in the middle of a read.
        start_read(32'h0000_0040);
        run(3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk1("t6_valid", resp_valid, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_perr", protocol_error, 1'b0);
        chk1("t6_wbp", wb_pending, 1'b0);
        chk128("t6_data", resp_cacheline, 128'd0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk1("t6_no_resp", resp_valid, 1'b0);
        end
        start_read(32'h0000_0040);
        run(7);
        chk1("t6_new_valid", resp_valid, 1'b1);
        chk128("t6_new_data", resp_cacheline, D1);
        run(2);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            r = $urandom();
            if ($urandom_range(0, 3) != 0) idx = 10'($urandom_range(0, 7));
            else idx = 10'($urandom_range(0, 1023));
            req_addr          = {r[31:14], idx, r[3:0]};
            reset             = ($urandom_range(0, 199) == 0);
            req_read_valid    = ($urandom_range(0, 99) < 30);
            req_evict_wren    = ($urandom_range(0, 99) < 30);
            hotlink_interrupt = ($urandom_range(0, 99) < 40);
            evict_cacheline   = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
        end
        reset = 1'b0; req_read_valid = 1'b0; req_evict_wren = 1'b0; hotlink_interrupt = 1'b0;
        run(30);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
